// File: rtl/data_mem_responder.sv
// Byte-addressed big-endian data memory with a single outstanding request and fixed latency.
// Define DMEM_ERR_CHECK_EN to reject misaligned/out-of-range accesses instead of wrapping them.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] address,
    input  logic [3:0]  xfer_size,
    input  logic [63:0] write_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] read_data,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]  mem_q [DEPTH];

    logic          accept;
    logic          size_ok;
    logic          req_err;
    logic [AW-1:0] base;
    logic [AW-1:0] size_mask;
    logic [6:0]    shamt;
    logic [63:0]   gathered;
    logic [63:0]   load_data;
    logic [63:0]   store_word;

    assign accept    = (state_q == StIdle) && req_valid;
    assign size_mask = AW'(xfer_size) - AW'(1);

    always_comb begin
        case (xfer_size)
            4'd1, 4'd2, 4'd4, 4'd8: size_ok = 1'b1;
            default:                size_ok = 1'b0;
        endcase
    end

`ifdef DMEM_ERR_CHECK_EN
    logic misaligned;
    logic out_of_range;

    assign misaligned   = (address[3:0] & (xfer_size - 4'd1)) != 4'd0;
    assign out_of_range = address >= 64'(DEPTH);
    assign req_err      = !size_ok || misaligned || out_of_range;
    assign base         = address[AW-1:0];
`else
    logic unused_addr_hi;

    // Upper address bits wrap away; low bits are forced to natural alignment.
    assign unused_addr_hi = ^address[63:AW];
    assign req_err        = !size_ok;
    assign base           = address[AW-1:0] & ~size_mask;
`endif

    // Datum is left-justified so byte i of the access always sits at bits [63-8i -: 8].
    assign shamt      = {3'b000, 4'd8 - xfer_size} << 3;
    assign store_word = write_data << shamt;

    always_comb begin
        gathered = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < xfer_size) begin
                gathered[63-8*i -: 8] = mem_q[base + AW'(i)];
            end
        end
        load_data = gathered >> shamt;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err && !reset) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < xfer_size) begin
                    mem_q[base + AW'(i)] <= store_word[63-8*i -: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rdata_d = (req_write || req_err) ? '0 : load_data;
                    err_d   = req_err;
                    if (LATENCY > 1) begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign read_data  = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH=128, LATENCY=2).
module tb_data_mem_responder;

    localparam int unsigned DEPTH   = 128;
    localparam int unsigned LATENCY = 2;
    localparam logic [63:0] PAT     = 64'h0123_4567_89AB_CDEF;

    localparam logic [63:0] LD_A [6] = '{64'd16, 64'd16, 64'd23, 64'd20, 64'd18, 64'd22};
    localparam logic [3:0]  LD_S [6] = '{4'd8, 4'd1, 4'd1, 4'd4, 4'd2, 4'd2};
    localparam logic [63:0] LD_E [6] = '{PAT, 64'h01, 64'hEF, 64'h89AB_CDEF, 64'h4567, 64'hCDEF};

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] address;
    logic [3:0]  xfer_size;
    logic [63:0] write_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] read_data;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .address    (address),
        .xfer_size  (xfer_size),
        .write_data (write_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .read_data  (read_data),
        .resp_err   (resp_err)
    );

    // Present one request for a single edge, then scramble the fields.
    task automatic send(input logic w, input logic [63:0] a, input logic [3:0] sz,
                        input logic [63:0] wd);
        @(negedge clk);
        req_write  = w;
        address    = a;
        xfer_size  = sz;
        write_data = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = ~w;
        address    = ~a;
        xfer_size  = 4'd3;
        write_data = ~wd;
    endtask

    // n = number of negedges after the accept edge until resp_valid is seen; -1 on timeout.
    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_valid !== 1'b1 && n < 20);
        if (resp_valid !== 1'b1) n = -1;
    endtask

    task automatic finish_resp();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        address    = '0;
        xfer_size  = 4'd8;
        write_data = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, resp_err} !== 3'b100 || read_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/vld/err=%b data=%h, want 100 data 0",
                     {req_ready, resp_valid, resp_err}, read_data);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: req_ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_store();
        int n;
        send(1'b1, 64'd16, 4'd8, PAT);
        wait_resp(n);
        n_checks++;
        if (n != int'(LATENCY) || read_data !== 64'd0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL store16: latency %0d data %h err %b, want latency %0d data 0 err 0",
                     n, read_data, resp_err, LATENCY);
        end
        finish_resp();
        n_checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL store_consume: vld/rdy=%b, want 01", {resp_valid, req_ready});
        end
    endtask

    task automatic test_load();
        int n;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, LD_A[i], LD_S[i], '0);
            wait_resp(n);
            n_checks++;
            if (n != int'(LATENCY) || read_data !== LD_E[i] || resp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL load[%0d] addr %0d size %0d: latency %0d data %h err %b, want %0d %h 0",
                         i, LD_A[i], LD_S[i], n, read_data, resp_err, LATENCY, LD_E[i]);
            end
            finish_resp();
        end
    endtask

    task automatic test_backpressure();
        int n;
        resp_ready = 1'b0;
        send(1'b0, 64'd20, 4'd4, '0);
        wait_resp(n);
        // Competing store held valid throughout; it must never be accepted.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        address    = 64'd16;
        xfer_size  = 4'd8;
        write_data = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({resp_valid, req_ready, resp_err} !== 3'b100 || read_data !== 64'h89AB_CDEF) begin
                n_fail++;
                $display("FAIL hold[%0d]: vld/rdy/err=%b data %h, want 100 data 89abcdef",
                         i, {resp_valid, req_ready, resp_err}, read_data);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_consume: vld/rdy=%b, want 01", {resp_valid, req_ready});
        end
        req_valid = 1'b0;
        send(1'b0, 64'd16, 4'd8, '0);
        wait_resp(n);
        n_checks++;
        if (read_data !== PAT || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_store: data %h err %b, want %h 0", read_data, resp_err, PAT);
        end
        finish_resp();
    endtask

    task automatic test_sizes();
        int n;
        send(1'b1, 64'd40, 4'd8, 64'd0);
        wait_resp(n);
        finish_resp();
        send(1'b1, 64'd40, 4'd4, 64'hDEAD_BEEF_CAFE_F00D);
        wait_resp(n);
        finish_resp();
        send(1'b1, 64'd32, 4'd2, 64'hFFFF_FFFF_FFFF_BEEF);
        wait_resp(n);
        finish_resp();
        send(1'b0, 64'd40, 4'd8, '0);
        wait_resp(n);
        n_checks++;
        if (read_data !== 64'hCAFE_F00D_0000_0000) begin
            n_fail++;
            $display("FAIL store_size4: data %h, want cafef00d00000000", read_data);
        end
        finish_resp();
        send(1'b0, 64'd33, 4'd1, '0);
        wait_resp(n);
        n_checks++;
        if (read_data !== 64'hEF) begin
            n_fail++;
            $display("FAIL store_size2_lo: data %h, want ef", read_data);
        end
        finish_resp();
    endtask

    task automatic test_illegal();
        int n;
        send(1'b1, 64'd16, 4'd3, 64'd0);
        wait_resp(n);
        n_checks++;
        if (resp_err !== 1'b1 || read_data !== 64'd0) begin
            n_fail++;
            $display("FAIL size3_store: err %b data %h, want 1 0", resp_err, read_data);
        end
        finish_resp();
        send(1'b0, 64'd16, 4'd0, '0);
        wait_resp(n);
        n_checks++;
        if (resp_err !== 1'b1 || read_data !== 64'd0) begin
            n_fail++;
            $display("FAIL size0_load: err %b data %h, want 1 0", resp_err, read_data);
        end
        finish_resp();
        send(1'b0, 64'd16, 4'd8, '0);
        wait_resp(n);
        n_checks++;
        if (read_data !== PAT || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_no_write: data %h err %b, want %h 0", read_data, resp_err, PAT);
        end
        finish_resp();
    endtask

    task automatic test_addr_mode();
        int n;
`ifdef DMEM_ERR_CHECK_EN
        send(1'b1, 64'd18, 4'd4, '1);
        wait_resp(n);
        n_checks++;
        if (resp_err !== 1'b1 || read_data !== 64'd0) begin
            n_fail++;
            $display("FAIL misaligned_store: err %b data %h, want 1 0", resp_err, read_data);
        end
        finish_resp();
        send(1'b0, 64'd144, 4'd8, '0);
        wait_resp(n);
        n_checks++;
        if (resp_err !== 1'b1 || read_data !== 64'd0) begin
            n_fail++;
            $display("FAIL out_of_range_load: err %b data %h, want 1 0", resp_err, read_data);
        end
        finish_resp();
        send(1'b0, 64'd16, 4'd8, '0);
        wait_resp(n);
        n_checks++;
        if (read_data !== PAT || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_write: data %h err %b, want %h 0", read_data, resp_err, PAT);
        end
        finish_resp();
`else
        send(1'b0, 64'd18, 4'd4, '0);
        wait_resp(n);
        n_checks++;
        if (read_data !== 64'h0123_4567 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL align_load18: data %h err %b, want 01234567 0", read_data, resp_err);
        end
        finish_resp();
        send(1'b0, 64'd144, 4'd8, '0);
        wait_resp(n);
        n_checks++;
        if (read_data !== PAT || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_load144: data %h err %b, want %h 0", read_data, resp_err, PAT);
        end
        finish_resp();
        send(1'b1, 64'd184, 4'd8, 64'h1122_3344_5566_7788);
        wait_resp(n);
        finish_resp();
        send(1'b1, 64'd61, 4'd2, 64'h0000_0000_0000_AABB);
        wait_resp(n);
        finish_resp();
        send(1'b0, 64'd56, 4'd8, '0);
        wait_resp(n);
        n_checks++;
        if (read_data !== 64'h1122_3344_AABB_7788 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_align_store: data %h err %b, want 11223344aabb7788 0",
                     read_data, resp_err);
        end
        finish_resp();
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        // Load dropped in WAIT: no response ever, outputs cleared.
        send(1'b0, 64'd16, 4'd8, '0);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({resp_valid, req_ready, resp_err} !== 3'b010 || read_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_state: vld/rdy/err=%b data %h, want 010 data 0",
                     {resp_valid, req_ready, resp_err}, read_data);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: req_ready=%b, want 1", req_ready);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_resp: resp_valid high %0d cycles, want 0", seen);
        end
        // Store dropped in WAIT: memory keeps the write.
        send(1'b1, 64'd48, 4'd8, 64'hA5A5_5A5A_0F0F_F0F0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send(1'b0, 64'd48, 4'd8, '0);
        wait_resp(n);
        n_checks++;
        if (n != int'(LATENCY) || read_data !== 64'hA5A5_5A5A_0F0F_F0F0) begin
            n_fail++;
            $display("FAIL reset_mid_store_kept: latency %0d data %h, want %0d a5a55a5a0f0ff0f0",
                     n, read_data, LATENCY);
        end
        finish_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_backpressure();
        test_sizes();
        test_illegal();
        test_addr_mode();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
